// File: rtl/zeus_tx_arb_pkg.sv
// Shared types and constants for the UDP TX packet arbiter.
package zeus_tx_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  localparam int STATS_CNT_W = 32;
endpackage

// File: rtl/tx_rr_picker.sv
// Combinational round-robin picker: first requester found searching upward,
// cyclically, from last_grant+1.
module tx_rr_picker
  import zeus_tx_arb_pkg::*;
#(
  parameter  int NUM_SOURCES   = 4,
  localparam int SRC_IDX_WIDTH = $clog2(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0]   req,
  input  logic [SRC_IDX_WIDTH-1:0] last_grant,
  output logic                     any_req,
  output logic [SRC_IDX_WIDTH-1:0] winner_idx
);

  always_comb begin
    logic [SRC_IDX_WIDTH-1:0] v_idx;
    any_req    = 1'b0;
    winner_idx = '0;
    v_idx      = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      v_idx = SRC_IDX_WIDTH'((int'(last_grant) + 1 + k) % NUM_SOURCES);
      if (!any_req && req[v_idx]) begin
        any_req    = 1'b1;
        winner_idx = v_idx;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding the UDP TX AXI-Stream input.
// Define ZEUS_TX_ARB_STATS_EN to add per-source packet/beat counters.
module udp_tx_arbiter
  import zeus_tx_arb_pkg::*;
#(
  parameter  int NUM_SOURCES   = 4,
  parameter  int DATA_WIDTH    = 512,
  localparam int SRC_IDX_WIDTH = $clog2(NUM_SOURCES),
  localparam int KEEP_W        = DATA_WIDTH / 8
) (
  input  logic                              tx_axis_aclk,
  input  logic                              tx_axis_aresetn,
  input  logic                              arb_enable,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES*KEEP_W-1:0]     s_axis_tkeep,
  input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
  input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
  output logic [NUM_SOURCES-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [KEEP_W-1:0]                 m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              grant_valid,
  output logic [SRC_IDX_WIDTH-1:0]          grant_idx,
  output logic                              idle
`ifdef ZEUS_TX_ARB_STATS_EN
  ,
  input  logic                              stats_clear,
  output logic [NUM_SOURCES*STATS_CNT_W-1:0] pkt_count,
  output logic [NUM_SOURCES*STATS_CNT_W-1:0] beat_count
`endif
);

  arb_state_t                          r_state, w_state_nxt;
  logic [SRC_IDX_WIDTH-1:0]            r_grant_idx, r_last_grant, w_winner;
  logic                                w_any_req, w_busy, w_accept, w_eop;
  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] w_tdata;
  logic [NUM_SOURCES-1:0][KEEP_W-1:0]     w_tkeep;

  assign w_tdata = s_axis_tdata;
  assign w_tkeep = s_axis_tkeep;

  tx_rr_picker #(.NUM_SOURCES(NUM_SOURCES)) u_picker (
    .req        (s_axis_tvalid),
    .last_grant (r_last_grant),
    .any_req    (w_any_req),
    .winner_idx (w_winner)
  );

  assign w_busy   = (r_state == ARB_BUSY);
  assign w_accept = m_axis_tvalid && m_axis_tready;
  assign w_eop    = w_accept && m_axis_tlast;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (arb_enable && w_any_req) w_state_nxt = ARB_BUSY;
      ARB_BUSY: if (w_eop)                   w_state_nxt = ARB_IDLE;
      default:                               w_state_nxt = ARB_IDLE;
    endcase
  end

  // Reset leaves last_grant at the top index so source 0 wins first.
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_state      <= ARB_IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= SRC_IDX_WIDTH'(NUM_SOURCES - 1);
    end else begin
      r_state <= w_state_nxt;
      if (!w_busy && w_state_nxt == ARB_BUSY) r_grant_idx  <= w_winner;
      if (w_eop)                              r_last_grant <= r_grant_idx;
    end
  end

  // Zero-latency mux of the locked source; everything is 0 outside BUSY.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (w_busy) begin
      m_axis_tdata               = w_tdata[r_grant_idx];
      m_axis_tkeep               = w_tkeep[r_grant_idx];
      m_axis_tvalid              = s_axis_tvalid[r_grant_idx];
      m_axis_tlast               = s_axis_tlast[r_grant_idx];
      s_axis_tready[r_grant_idx] = m_axis_tready;
    end
  end

  assign grant_valid = w_busy;
  assign grant_idx   = r_grant_idx;
  assign idle        = !w_busy;

`ifdef ZEUS_TX_ARB_STATS_EN
  logic [NUM_SOURCES-1:0][STATS_CNT_W-1:0] r_pkt_cnt, r_beat_cnt;

  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      r_pkt_cnt  <= '0;
      r_beat_cnt <= '0;
    end else if (stats_clear) begin
      r_pkt_cnt  <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) r_beat_cnt[r_grant_idx] <= r_beat_cnt[r_grant_idx] + STATS_CNT_W'(1);
      if (w_eop)    r_pkt_cnt[r_grant_idx]  <= r_pkt_cnt[r_grant_idx] + STATS_CNT_W'(1);
    end
  end

  assign pkt_count  = r_pkt_cnt;
  assign beat_count = r_beat_cnt;
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed table-driven bench for udp_tx_arbiter (4 sources, 32-bit data).
module tb_udp_tx_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            arb_en;
  logic [NS*DW-1:0] s_tdata;
  logic [NS*KW-1:0] s_tkeep;
  logic [NS-1:0]   s_valid, s_last, s_ready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_valid, m_last, m_ready;
  logic            gv;
  logic [1:0]      gi;
  logic            idle;
`ifdef ZEUS_TX_ARB_STATS_EN
  logic            stats_clear;
  logic [NS*32-1:0] pkt_count, beat_count;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  udp_tx_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
    .tx_axis_aclk    (clk),
    .tx_axis_aresetn (rst_n),
    .arb_enable      (arb_en),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_valid),
    .s_axis_tlast    (s_last),
    .s_axis_tready   (s_ready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_valid),
    .m_axis_tlast    (m_last),
    .m_axis_tready   (m_ready),
    .grant_valid     (gv),
    .grant_idx       (gi),
    .idle            (idle)
`ifdef ZEUS_TX_ARB_STATS_EN
    ,
    .stats_clear     (stats_clear),
    .pkt_count       (pkt_count),
    .beat_count      (beat_count)
`endif
  );

  typedef struct {
    logic [3:0] v, l;
    logic       mr;
    logic       e_mv, e_ml;
    logic [3:0] e_rdy;
    logic [1:0] e_gi;
    logic       e_idle;
  } vec_t;

  localparam int NROW = 29;
  vec_t tbl [NROW];

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic mr, logic mv,
                              logic ml, logic [3:0] rdy, logic [1:0] g, logic id);
    vec_t t;
    t.v = v; t.l = l; t.mr = mr; t.e_mv = mv; t.e_ml = ml;
    t.e_rdy = rdy; t.e_gi = g; t.e_idle = id;
    return t;
  endfunction

  function automatic logic [DW-1:0] pat(int row, int src);
    return {8'hD0 ^ 8'(row), 8'(src), 16'h5A00 + 16'(row)};
  endfunction

  task automatic drive_data(int row);
    for (int i = 0; i < NS; i++) begin
      s_tdata[i*DW +: DW] = pat(row, i);
      s_tkeep[i*KW +: KW] = KW'(i + 1);
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // contention from reset: grants 0,1,2,3,0 with one idle cycle between
    tbl[0]  = mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 0, 1);
    tbl[1]  = mk(4'b1111, 4'b0000, 1, 1, 0, 4'b0001, 0, 0);
    tbl[2]  = mk(4'b1111, 4'b1111, 1, 1, 1, 4'b0001, 0, 0);
    tbl[3]  = mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 0, 1);
    tbl[4]  = mk(4'b1111, 4'b0000, 1, 1, 0, 4'b0010, 1, 0);
    tbl[5]  = mk(4'b1111, 4'b1111, 1, 1, 1, 4'b0010, 1, 0);
    tbl[6]  = mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 1, 1);
    tbl[7]  = mk(4'b1111, 4'b0000, 1, 1, 0, 4'b0100, 2, 0);
    tbl[8]  = mk(4'b1111, 4'b1111, 1, 1, 1, 4'b0100, 2, 0);
    tbl[9]  = mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 2, 1);
    tbl[10] = mk(4'b1111, 4'b0000, 1, 1, 0, 4'b1000, 3, 0);
    tbl[11] = mk(4'b1111, 4'b1111, 1, 1, 1, 4'b1000, 3, 0);
    tbl[12] = mk(4'b1111, 4'b0000, 1, 0, 0, 4'b0000, 3, 1);
    tbl[13] = mk(4'b1111, 4'b0000, 1, 1, 0, 4'b0001, 0, 0);
    tbl[14] = mk(4'b1111, 4'b1111, 1, 1, 1, 4'b0001, 0, 0);
    // single source 2, 3-beat packet
    tbl[15] = mk(4'b0100, 4'b0000, 1, 0, 0, 4'b0000, 0, 1);
    tbl[16] = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0100, 2, 0);
    tbl[17] = mk(4'b0100, 4'b0000, 1, 1, 0, 4'b0100, 2, 0);
    tbl[18] = mk(4'b0100, 4'b0100, 1, 1, 1, 4'b0100, 2, 0);
    tbl[19] = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 2, 1);
    // backpressure: source 1 4-beat packet, source 2 also waiting
    tbl[20] = mk(4'b0110, 4'b0000, 1, 0, 0, 4'b0000, 2, 1);
    tbl[21] = mk(4'b0110, 4'b0000, 1, 1, 0, 4'b0010, 1, 0);
    tbl[22] = mk(4'b0110, 4'b0000, 0, 1, 0, 4'b0000, 1, 0);
    tbl[23] = mk(4'b0110, 4'b0000, 1, 1, 0, 4'b0010, 1, 0);
    tbl[24] = mk(4'b0110, 4'b0000, 0, 1, 0, 4'b0000, 1, 0);
    tbl[25] = mk(4'b0110, 4'b0000, 1, 1, 0, 4'b0010, 1, 0);
    tbl[26] = mk(4'b0110, 4'b0010, 0, 1, 1, 4'b0000, 1, 0);
    tbl[27] = mk(4'b0110, 4'b0010, 1, 1, 1, 4'b0010, 1, 0);
    tbl[28] = mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 1, 1);

    rst_n = 1'b0; arb_en = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b1;
    s_tdata = '0; s_tkeep = '0;
`ifdef ZEUS_TX_ARB_STATS_EN
    stats_clear = 1'b0;
`endif
    #2;
    chk("reset m_valid", 64'(m_valid), 0);
    chk("reset s_ready", 64'(s_ready), 0);
    chk("reset idle", 64'(idle), 1);
    chk("reset grant", 64'({gv, gi}), 0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    for (int r = 0; r < NROW; r++) begin
      s_valid = tbl[r].v; s_last = tbl[r].l; m_ready = tbl[r].mr;
      drive_data(r);
      #3;
      chk($sformatf("row%0d m_valid", r), 64'(m_valid), 64'(tbl[r].e_mv));
      chk($sformatf("row%0d m_last", r), 64'(m_last), 64'(tbl[r].e_ml));
      chk($sformatf("row%0d s_ready", r), 64'(s_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("row%0d idle", r), 64'(idle), 64'(tbl[r].e_idle));
      chk($sformatf("row%0d grant_valid", r), 64'(gv), 64'(!tbl[r].e_idle));
      chk($sformatf("row%0d grant_idx", r), 64'(gi), 64'(tbl[r].e_gi));
      chk($sformatf("row%0d tdata", r), 64'(m_tdata),
          tbl[r].e_idle ? 64'd0 : 64'(pat(r, int'(tbl[r].e_gi))));
      chk($sformatf("row%0d tkeep", r), 64'(m_tkeep),
          tbl[r].e_idle ? 64'd0 : 64'(tbl[r].e_gi) + 64'd1);
      tick;
    end

    // quiesce: source 0 5-beat packet, enable dropped on beat 2, source 1 waiting
    s_valid = 4'b0011; s_last = '0; m_ready = 1'b1; arb_en = 1'b1;
    tick;
    #1 chk("quiesce grant0", 64'({gv, gi}), 64'({1'b1, 2'd0}));
    tick;
    arb_en = 1'b0;
    tick; tick; tick;
    s_last = 4'b0001;
    #1 chk("quiesce beat5 last", 64'(m_last), 1);
    tick;
    s_last = '0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("quiesce idle c%0d", c), 64'({idle, gv, m_valid}), 64'(3'b100));
      tick;
    end
    arb_en = 1'b1;
    tick;
    #1 chk("reenable grant1", 64'({gv, gi}), 64'({1'b1, 2'd1}));
    s_last = 4'b0010;
    tick;
    s_valid = '0; s_last = '0;
    #1 chk("reenable done idle", 64'(idle), 1);
    tick;

    // async reset mid-packet
    s_valid = 4'b0100;
    tick;
    #1 chk("pre-reset busy", 64'({m_valid, gi}), 64'({1'b1, 2'd2}));
    #1 rst_n = 1'b0;
    #1;
    chk("async rst m_valid", 64'(m_valid), 0);
    chk("async rst s_ready", 64'(s_ready), 0);
    chk("async rst idle", 64'({idle, gv}), 64'(2'b10));
    @(posedge clk);
    #2 rst_n = 1'b1;
    s_valid = 4'b1111; s_last = '0;
    tick;
    #1 chk("post-reset grant0", 64'({gv, gi}), 64'({1'b1, 2'd0}));
    s_last = 4'b0001;
    tick;
    s_valid = '0; s_last = '0;
    tick;

`ifdef ZEUS_TX_ARB_STATS_EN
    stats_clear = 1'b1;
    tick;
    stats_clear = 1'b0;
    for (int p = 0; p < 3; p++) begin
      s_valid = 4'b1000; s_last = '0;
      tick; tick;
      s_last = 4'b1000;
      tick;
      s_valid = '0; s_last = '0;
    end
    #1;
    chk("pkt_count[3]", 64'(pkt_count[96 +: 32]), 3);
    chk("beat_count[3]", 64'(beat_count[96 +: 32]), 6);
    chk("pkt_count[0]", 64'(pkt_count[0 +: 32]), 0);
    s_valid = 4'b1000;
    tick; tick;
    s_last = 4'b1000; stats_clear = 1'b1;
    tick;
    stats_clear = 1'b0; s_valid = '0; s_last = '0;
    #1;
    chk("clear pkt_count", 64'(pkt_count[96 +: 32]), 0);
    chk("clear beat_count", 64'(beat_count[96 +: 32]), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
